booth_mul_sequencer: RTL and testbench
======================================

Name: booth_mul_sequencer

Overview:
Upstream and downstream wrapper for the sequential Booth multiplier core (BoothAlgo, 32x32 signed, 64-bit product).
- Accepts operand pairs over a valid/ready handshake.
- Holds operands stable on the core's inputs, pulses the core's reset, and waits a fixed cycle budget.
- Captures the 64-bit product and presents it over a valid/ready handshake.
- Replaces the hand-timed reset/wait sequencing around the core with a protocol-driven front end.

Parameters:
- WIDTH, 32: operand width; product is 2*WIDTH.
- RST_CYCLES, 3: cycles the core is held in reset per operation (min 1).
- RUN_CYCLES, 40: cycles after core reset release before the product is sampled (min 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high block reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_m  in  WIDTH  multiplicand, two's complement.
- in_q  in  WIDTH  multiplier, two's complement.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_prod  out  2*WIDTH  signed product.
- busy  out  1  high in any state other than IDLE.
- mul_m  out  WIDTH  to core inputM.
- mul_q  out  WIDTH  to core inputQ.
- mul_rst  out  1  to core reset, active-high.
- mul_out  in  2*WIDTH  from core out.

Behaviour:
Interface:
- One clock, clk.
- Reset is synchronous and active-high, port name reset.

Reset values:
- in_ready=0, out_valid=0, out_prod=0, busy=0, mul_m=0, mul_q=0, mul_rst=1.
- State=IDLE, counter=0.
- in_ready rises the cycle after reset deasserts.

State machine (registered outputs):
- IDLE
  - in_ready=1, mul_rst=1.
  - When in_valid and in_ready: latch in_m/in_q into mul_m/mul_q, load counter=RST_CYCLES-1, go to CLEAR.
- CLEAR
  - mul_rst=1, in_ready=0.
  - Counter decrements each cycle.
  - At 0: deassert mul_rst on the next edge, load counter=RUN_CYCLES-1, go to RUN.
- RUN
  - mul_rst=0.
  - Counter decrements each cycle.
  - At 0: out_prod<=mul_out, out_valid<=1, mul_rst<=1, go to DONE.
- DONE
  - out_valid=1; out_prod held stable while out_ready=0.
  - When out_valid and out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 in DONE. There is no overlap and only one operation is in flight at a time.

Timing and latency:
- Accept edge to out_valid rising: exactly 1+RST_CYCLES+RUN_CYCLES cycles (44 at defaults).
- Minimum initiation interval: latency + 1 handshake cycle + 1 IDLE cycle.

Operand and data rules:
- mul_m/mul_q are constant from the accept edge until the next accept.
- Operands are signed; no width extension is applied at the input.
- out_prod is mul_out passed through unmodified.

Boundary conditions:
- reset asserted in any state:
  - Next edge returns the block to IDLE with the reset values above.
  - Any in-flight product is discarded.
  - No out_valid pulse is produced.
- in_valid while busy: ignored (in_ready=0). Upstream must hold the pair.
- out_ready high before out_valid: no effect.
- Counter reaching 0 with RST_CYCLES=1 or RUN_CYCLES=1: single-cycle state, no wrap.
- Counter never underflows; its width is $clog2(max(RST_CYCLES,RUN_CYCLES))+1.

Optional Feature:
- Macro: BOOTH_SEQ_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, an accepted pair with in_m==0 or in_q==0 skips CLEAR/RUN.
  - out_prod<=0 and out_valid<=1 on the accept edge +1 (latency 1).
  - mul_rst stays 1 throughout.
  - mul_m/mul_q are still latched.
- Undefined: zero operands take the full RST_CYCLES+RUN_CYCLES path like any other operand.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, CLEAR, RUN, DONE}.
  - Default WIDTH, RST_CYCLES, RUN_CYCLES localparams.
  - Counter width function.
- One natural sub-module: booth_seq_counter, a loadable down-counter with a zero flag shared by CLEAR and RUN.
- The FSM and handshake registers stay in the top.

Test Plan:
1. Reset held 3 cycles, then in_m=7, in_q=2 with out_ready=1 -> out_valid exactly 44 cycles after accept; out_prod=14; busy high throughout.
2. in_m=-2, in_q=-5, then in_m=-5, in_q=2 back-to-back -> products 10 then -10 (64'hFFFF_FFFF_FFFF_FFF6); second accept only after first out handshake.
3. in_m=32'hFFFF_FF01, in_q=32'h139, out_ready=0 for 10 cycles after out_valid -> out_prod=-79815 held stable, out_valid held; clears one cycle after out_ready=1.
4. Accept 3*3, assert reset 20 cycles in -> next cycle IDLE, mul_rst=1, no out_valid; a following 3*3 returns 9.
5. in_valid asserted continuously with changing data while busy -> only the pair present at the accept edge is multiplied; mul_m/mul_q unchanged during CLEAR/RUN.
6. With BOOTH_SEQ_ZERO_BYPASS_EN: in_m=32'hF00000F5, in_q=0 -> out_prod=0, out_valid 1 cycle after accept, mul_rst never deasserted. Without the macro: out_prod=0 after 44 cycles.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding, default sizing and counter width helper for booth_mul_sequencer
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;
  localparam int WIDTH_DEF = 32;
  localparam int RST_CYCLES_DEF = 3;
  localparam int RUN_CYCLES_DEF = 40;
  function automatic int cnt_w(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/booth_mul_sequencer_if.sv
// booth_mul_sequencer_if: operand-in / product-out valid-ready handshake bundle
interface booth_mul_sequencer_if #(parameter int WIDTH = 32) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_m;
  logic [WIDTH-1:0]   in_q;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  modport master (output in_valid, in_m, in_q, out_ready, input in_ready, out_valid, out_prod);
  modport slave (input in_valid, in_m, in_q, out_ready, output in_ready, out_valid, out_prod);
endinterface

// File: rtl/booth_seq_counter.sv
// booth_seq_counter: loadable down-counter that parks at zero, shared by the CLEAR and RUN phases
module booth_seq_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero = cnt_q == '0;
  // load wins; otherwise count down and hold at zero so it never underflows
  always_comb cnt_d = load ? load_val : (zero ? cnt_q : cnt_q - 1'b1);
  // counter register
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: handshake front end that resets, runs and samples a sequential Booth core; BOOTH_SEQ_ZERO_BYPASS_EN enables the zero-operand shortcut
module booth_mul_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  booth_mul_sequencer_if.slave  bus,
  output logic                  busy,
  output logic [WIDTH-1:0]      mul_m,
  output logic [WIDTH-1:0]      mul_q,
  output logic                  mul_rst,
  input  logic [2*WIDTH-1:0]    mul_out
);
  localparam int CW = cnt_w(RST_CYCLES, RUN_CYCLES);
  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_prod_q, out_prod_d;
  logic [WIDTH-1:0]   mul_m_q, mul_m_d;
  logic [WIDTH-1:0]   mul_q_q, mul_q_d;
  logic               mul_rst_q, mul_rst_d;
  logic               cnt_load, cnt_zero;
  logic [CW-1:0]      cnt_val;
  logic               accept, zero_op;
  assign accept = state_q == IDLE && bus.in_valid && in_ready_q;
`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
  assign zero_op = bus.in_m == '0 || bus.in_q == '0;
`else
  assign zero_op = 1'b0;
`endif
  booth_seq_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );
  // next-state and registered-output logic for the accept / clear / run / deliver sequence
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_prod_d  = out_prod_q;
    mul_m_d     = mul_m_q;
    mul_q_d     = mul_q_q;
    mul_rst_d   = mul_rst_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    case (state_q)
      IDLE: begin
        in_ready_d = !accept;
        mul_rst_d  = 1'b1;
        if (accept) begin
          mul_m_d = bus.in_m;
          mul_q_d = bus.in_q;
          if (zero_op) begin
            state_d     = DONE;
            out_prod_d  = '0;
            out_valid_d = 1'b1;
          end else begin
            state_d  = CLEAR;
            cnt_load = 1'b1;
            cnt_val  = CW'(RST_CYCLES - 1);
          end
        end
      end
      CLEAR: if (cnt_zero) begin
        state_d   = RUN;
        mul_rst_d = 1'b0;
        cnt_load  = 1'b1;
        cnt_val   = CW'(RUN_CYCLES - 1);
      end
      RUN: if (cnt_zero) begin
        state_d     = DONE;
        out_prod_d  = mul_out;
        out_valid_d = 1'b1;
        mul_rst_d   = 1'b1;
      end
      DONE: if (bus.out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset discards any operation in flight
  always_ff @(posedge clk)
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      mul_m_q     <= '0;
      mul_q_q     <= '0;
      mul_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_prod_q  <= out_prod_d;
      mul_m_q     <= mul_m_d;
      mul_q_q     <= mul_q_d;
      mul_rst_q   <= mul_rst_d;
    end
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = out_prod_q;
  assign busy          = state_q != IDLE;
  assign mul_m         = mul_m_q;
  assign mul_q         = mul_q_q;
  assign mul_rst       = mul_rst_q;
endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb_booth_mul_sequencer: vector table, corner sequences and random operands against a behavioural core and product model
module tb_booth_mul_sequencer;
  localparam int W   = 32;
  localparam int RC  = 3;
  localparam int NC  = 40;
  localparam int LAT = 1 + RC + NC;
`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  booth_mul_sequencer_if #(.WIDTH(W)) bus ();
  logic           busy, mul_rst;
  logic [W-1:0]   mul_m, mul_q;
  logic [2*W-1:0] mul_out;
  int n_cmp = 0;
  int n_bad = 0;
  booth_mul_sequencer #(.WIDTH(W), .RST_CYCLES(RC), .RUN_CYCLES(NC)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .mul_m   (mul_m),
    .mul_q   (mul_q),
    .mul_rst (mul_rst),
    .mul_out (mul_out)
  );
  function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] q);
    logic signed [63:0] a, b;
    a = $signed(m);
    b = $signed(q);
    return a * b;
  endfunction
  // behavioural core: output is junk until it has been out of reset for W+1 cycles
  int run_cnt = 0;
  always @(posedge clk) run_cnt <= mul_rst ? 0 : run_cnt + 1;
  assign mul_out = run_cnt >= W + 1 ? ref_prod(mul_m, mul_q) : {32'hBAD0_C0DE, 32'(run_cnt)};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_op(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp,
                        input int hold, input bit churn, input string nm);
    int t, cyc, rst_low, bad;
    logic [63:0] p;
    bit zb;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      tick;
      t++;
    end
    chk({nm, " ready"}, 64'(bus.in_ready), 64'd1);
    zb = BYP && (m == 0 || q == 0);
    bus.out_ready = hold == 0;
    bus.in_m = m;
    bus.in_q = q;
    bus.in_valid = 1'b1;
    tick;
    if (!churn) bus.in_valid = 1'b0;
    cyc = 1;
    rst_low = 0;
    bad = 0;
    while (!bus.out_valid && cyc < 200) begin
      if (!busy || bus.in_ready || mul_m !== m || mul_q !== q) bad++;
      if (!mul_rst) rst_low++;
      if (churn) begin
        bus.in_m = $urandom;
        bus.in_q = $urandom;
      end
      tick;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({nm, " latency"}, 64'(cyc), zb ? 64'd1 : 64'(LAT));
    chk({nm, " core run cycles"}, 64'(rst_low), zb ? 64'd0 : 64'(NC));
    chk({nm, " busy/ready/operands"}, 64'(bad), 64'd0);
    chk({nm, " prod"}, bus.out_prod, exp);
    p = bus.out_prod;
    bad = 0;
    repeat (hold) begin
      tick;
      if (!bus.out_valid || bus.out_prod !== p || bus.in_ready) bad++;
    end
    if (hold > 0) chk({nm, " hold"}, 64'(bad), 64'd0);
    bus.out_ready = 1'b1;
    tick;
    chk({nm, " valid drop"}, 64'(bus.out_valid), 64'd0);
    chk({nm, " idle"}, {62'd0, busy, bus.in_ready}, 64'd1);
  endtask
  typedef struct {
    logic [31:0] m;
    logic [31:0] q;
    logic [63:0] p;
    int          hold;
    bit          churn;
    string       nm;
  } vec_t;
  vec_t tv[6];
  initial begin
    int seen;
    logic [31:0] rm, rq;
    tv[0] = '{32'd7, 32'd2, 64'd14, 0, 1'b0, "7x2"};
    tv[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFB, 64'd10, 0, 1'b0, "-2x-5"};
    tv[2] = '{32'hFFFF_FFFB, 32'd2, 64'hFFFF_FFFF_FFFF_FFF6, 0, 1'b0, "-5x2"};
    tv[3] = '{32'hFFFF_FF01, 32'h139, -64'd79815, 10, 1'b0, "backpressure"};
    tv[4] = '{32'd1234, 32'd5678, 64'd7006652, 0, 1'b1, "churn"};
    tv[5] = '{32'hF000_00F5, 32'd0, 64'd0, 0, 1'b0, "zero"};
    bus.in_valid = 1'b0;
    bus.in_m = '0;
    bus.in_q = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick;
    chk("rst in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out_prod", bus.out_prod, 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst mul_m/q", {mul_m, mul_q}, 64'd0);
    chk("rst mul_rst", 64'(mul_rst), 64'd1);
    reset = 1'b0;
    tick;
    chk("in_ready after reset", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 6; i++) run_op(tv[i].m, tv[i].q, tv[i].p, tv[i].hold, tv[i].churn, tv[i].nm);
    bus.in_m = 32'd3;
    bus.in_q = 32'd3;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    repeat (20) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort mul_rst", 64'(mul_rst), 64'd1);
    chk("abort out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort mul_m", 64'(mul_m), 64'd0);
    seen = 0;
    repeat (60) begin
      tick;
      if (bus.out_valid) seen++;
    end
    chk("abort no product", 64'(seen), 64'd0);
    run_op(32'd3, 32'd3, 64'd9, 0, 1'b0, "3x3 after abort");
    for (int i = 0; i < 20; i++) begin
      rm = $urandom;
      rq = $urandom;
      if (i % 5 == 1) rm = 32'($signed($urandom_range(0, 20)) - 10);
      if (i % 7 == 3) rq = 32'h8000_0000;
      run_op(rm, rq, ref_prod(rm, rq), $urandom_range(0, 3), 1'b0, "random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1);
  end
endmodule
